// File: rtl/multiply_hilo_if.sv
// Issue-stage <-> multiply/HI-LO unit bus: multiply request, HI/LO moves and results.
// Handshake: start acts as a valid that is accepted on any rising edge where busy=0
// and no move (mthi/mtlo) is requested in the same cycle; busy acts as the inverted
// ready and the requester must hold start until it is accepted.
interface multiply_hilo_if;
  logic        start;
  logic        is_signed;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wr_data;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, is_signed, op_a, op_b, mthi, mtlo, wr_data,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, is_signed, op_a, op_b, mthi, mtlo, wr_data,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/multiply_hilo_unit.sv
// MULT/MULTU sequencer around a combinational unsigned multiplier, with HI/LO
// architectural registers and mthi/mtlo moves. Product is a LATENCY-cycle multicycle path.
module umultiplier (
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic [63:0] prod
);
  assign prod = {32'd0, in1} * {32'd0, in2};
endmodule

module multiply_hilo_unit #(
  parameter int LATENCY = 4  // legal range 1..15
) (
  input  logic                  clock,
  input  logic                  reset_n,
  multiply_hilo_if.slave        bus,
  output logic                  state_dbg
);
  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t      state, state_nx;
  logic [3:0]  count, count_nx;
  logic [31:0] mag_a, mag_a_nx;
  logic [31:0] mag_b, mag_b_nx;
  logic        neg, neg_nx;
  logic [31:0] hi, hi_nx;
  logic [31:0] lo, lo_nx;
  logic        done, done_nx;
  logic [63:0] prod;
  logic [63:0] result;
  logic        move;

  // Magnitude registers stay constant while BUSY, forming the multicycle path.
  umultiplier u_mul (
    .in1  (mag_a),
    .in2  (mag_b),
    .prod (prod)
  );

  assign result = neg ? (64'd0 - prod) : prod;
  assign move   = bus.mthi | bus.mtlo;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      count <= 4'd0;
      mag_a <= 32'd0;
      mag_b <= 32'd0;
      neg   <= 1'b0;
      hi    <= 32'd0;
      lo    <= 32'd0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      mag_a <= mag_a_nx;
      mag_b <= mag_b_nx;
      neg   <= neg_nx;
      hi    <= hi_nx;
      lo    <= lo_nx;
      done  <= done_nx;
    end
  end

  always_comb begin
    state_nx = state;
    count_nx = count;
    mag_a_nx = mag_a;
    mag_b_nx = mag_b;
    neg_nx   = neg;
    hi_nx    = hi;
    lo_nx    = lo;
    done_nx  = 1'b0;

    // A move always wins: it drops a pending start in IDLE and aborts a multiply in BUSY.
    if (bus.mthi) hi_nx = bus.wr_data;
    if (bus.mtlo) lo_nx = bus.wr_data;

    case (state)
      IDLE: begin
        if (!move && bus.start) begin
          mag_a_nx = (bus.is_signed && bus.op_a[31]) ? (32'd0 - bus.op_a) : bus.op_a;
          mag_b_nx = (bus.is_signed && bus.op_b[31]) ? (32'd0 - bus.op_b) : bus.op_b;
          neg_nx   = bus.is_signed & (bus.op_a[31] ^ bus.op_b[31]);
          count_nx = 4'(LATENCY - 1);
          state_nx = BUSY;
        end
      end
      BUSY: begin
        if (move) begin
          count_nx = 4'd0;
          state_nx = IDLE;
        end else if (count == 4'd0) begin
          hi_nx    = result[63:32];
          lo_nx    = result[31:0];
          done_nx  = 1'b1;
          state_nx = IDLE;
        end else begin
          count_nx = count - 4'd1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.busy  = (state == BUSY);
  assign bus.done  = done;
  assign bus.hi    = hi;
  assign bus.lo    = lo;
  assign state_dbg = state;
endmodule
